l1d_cache_ctrl: RTL

//  Sequencing FSM for the L1 data cache (2-way, 32 sets, 16B lines, write-through, read-allocate, no write-allocate).

---
 rtl/l1d_pkg.sv | 28 ++
 rtl/l1d_fill_buf.sv | 35 +++
 rtl/l1d_cache_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/l1d_pkg.sv
// l1d_pkg: m1 state codes, AXI constants and line helpers for the L1D controller.
package l1d_pkg;
    typedef enum logic [4:0] {
        S_IDLE       = 5'd0,
        S_RDTAG      = 5'd1,
        S_RDCHECK    = 5'd2,
        S_RDCACHE    = 5'd3,
        S_CACHETOCPU = 5'd4,
        S_AR         = 5'd5,
        S_R          = 5'd8,
        S_RDUPCACHE  = 5'd9,
        S_SRAMTOCPU  = 5'd10,
        S_WRTAG      = 5'd11,
        S_WRCHECK    = 5'd12,
        S_WRCACHE    = 5'd13,
        S_AW         = 5'd14,
        S_W          = 5'd15,
        S_B          = 5'd17
    } m1_state_e;

    localparam int          LINE_BEATS_DEF = 4;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  AXI_SIZE_4B    = 3'd2;

    function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] sel);
        return line[sel*32 +: 32];
    endfunction
endpackage

// File: rtl/l1d_fill_buf.sv
// l1d_fill_buf: beat counter and line assembly register for AXI line fills.
module l1d_fill_buf
    import l1d_pkg::*;
#(
    parameter int LINE_BEATS = LINE_BEATS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    beat_i,
    input  logic [31:0]             data_i,
    output logic [32*LINE_BEATS-1:0] line_o,
    output logic                    done_o
);
    localparam int CW = $clog2(LINE_BEATS);

    logic [CW-1:0]                cnt_q;
    logic [LINE_BEATS-1:0][31:0]  line_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            line_q <= '0;
        end else if (clr_i) begin
            cnt_q  <= '0;
        end else if (beat_i) begin
            line_q[cnt_q] <= data_i;
            cnt_q         <= cnt_q + 1'b1;
        end
    end

    // The beat count alone terminates the fill; RLAST is not trusted.
    assign done_o = beat_i && (cnt_q == CW'(LINE_BEATS - 1));
    assign line_o = line_q;
endmodule

// File: rtl/l1d_cache_ctrl.sv
// l1d_cache_ctrl: L1D sequencing FSM (read-allocate, write-through) mastering AXI fills and writes.
// Define L1D_PERF_CNT_EN to build the read-hit/read-miss/write performance counters.
module l1d_cache_ctrl
    import l1d_pkg::*;
#(
    parameter int LINE_BEATS = LINE_BEATS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_CPU_req,
    input  logic         i_CPU_we,
    input  logic [31:0]  i_CPU_A,
    input  logic [31:0]  i_CPU_DI,
    input  logic [31:0]  i_CPU_BWEB,
    output logic         o_CPU_done,
    output logic         o_CPU_stall,
    output logic [31:0]  o_CPU_DO,
    output logic [4:0]   o_m1_state,
    output logic [31:0]  o_DP_A,
    output logic [31:0]  o_DP_DI,
    output logic [31:0]  o_DP_BWEB,
    input  logic         i_m1_hit,
    input  logic [127:0] i_DA_DO,
    output logic [127:0] o_CPUW_RDATA,
    output logic [31:0]  o_ARADDR,
    output logic [3:0]   o_ARLEN,
    output logic [2:0]   o_ARSIZE,
    output logic [1:0]   o_ARBURST,
    output logic         o_ARVALID,
    input  logic         i_ARREADY,
    input  logic [31:0]  i_RDATA,
    input  logic         i_RLAST,
    input  logic         i_RVALID,
    output logic         o_RREADY,
    output logic [31:0]  o_AWADDR,
    output logic [3:0]   o_AWLEN,
    output logic [2:0]   o_AWSIZE,
    output logic [1:0]   o_AWBURST,
    output logic         o_AWVALID,
    input  logic         i_AWREADY,
    output logic [31:0]  o_WDATA,
    output logic [3:0]   o_WSTRB,
    output logic         o_WLAST,
    output logic         o_WVALID,
    input  logic         i_WREADY,
    input  logic         i_BVALID,
    output logic         o_BREADY,
    output logic [31:0]  o_rd_hit_cnt,
    output logic [31:0]  o_rd_miss_cnt,
    output logic [31:0]  o_wr_cnt
);
    m1_state_e    state_q, state_d;
    logic [31:0]  a_q, di_q, bweb_q;
    logic         accept, fill_done, done, unused_rlast;
    logic [127:0] fill_line;

    assign accept       = (state_q == S_IDLE) && i_CPU_req;
    assign unused_rlast = i_RLAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            di_q    <= '0;
            bweb_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q    <= i_CPU_A;
                di_q   <= i_CPU_DI;
                bweb_q <= i_CPU_BWEB;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       state_d = !i_CPU_req ? S_IDLE : i_CPU_we ? S_WRTAG : S_RDTAG;
            S_RDTAG:      state_d = S_RDCHECK;
            S_RDCHECK:    state_d = i_m1_hit ? S_RDCACHE : S_AR;
            S_RDCACHE:    state_d = S_CACHETOCPU;
            S_AR:         state_d = i_ARREADY ? S_R : S_AR;
            S_R:          state_d = fill_done ? S_RDUPCACHE : S_R;
            S_RDUPCACHE:  state_d = S_SRAMTOCPU;
            S_WRTAG:      state_d = S_WRCHECK;
            S_WRCHECK:    state_d = i_m1_hit ? S_WRCACHE : S_AW;
            S_WRCACHE:    state_d = S_AW;
            S_AW:         state_d = i_AWREADY ? S_W : S_AW;
            S_W:          state_d = i_WREADY ? S_B : S_W;
            S_B:          state_d = i_BVALID ? S_IDLE : S_B;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done         = (state_q == S_CACHETOCPU) || (state_q == S_SRAMTOCPU) || ((state_q == S_B) && i_BVALID);
        o_CPU_DO     = (state_q == S_CACHETOCPU) ? line_word(i_DA_DO, a_q[3:2]) :
                       (state_q == S_SRAMTOCPU)  ? line_word(fill_line, a_q[3:2]) : 32'h0;
        o_ARVALID    = state_q == S_AR;
        o_RREADY     = state_q == S_R;
        o_AWVALID    = state_q == S_AW;
        o_WVALID     = state_q == S_W;
        o_WLAST      = state_q == S_W;
        o_BREADY     = state_q == S_B;
        o_ARADDR     = {a_q[31:4], 4'h0};
        o_ARLEN      = 4'(LINE_BEATS - 1);
        o_ARSIZE     = AXI_SIZE_4B;
        o_ARBURST    = AXI_BURST_INCR;
        o_AWADDR     = a_q;
        o_AWLEN      = 4'h0;
        o_AWSIZE     = AXI_SIZE_4B;
        o_AWBURST    = AXI_BURST_INCR;
        o_WDATA      = di_q;
        o_WSTRB      = ~{bweb_q[24], bweb_q[16], bweb_q[8], bweb_q[0]};
    end

    assign o_CPU_done   = done;
    assign o_CPU_stall  = i_CPU_req && !done;
    assign o_m1_state   = state_q;
    assign o_DP_A       = a_q;
    assign o_DP_DI      = di_q;
    assign o_DP_BWEB    = bweb_q;
    assign o_CPUW_RDATA = fill_line;

    l1d_fill_buf #(.LINE_BEATS(LINE_BEATS)) u_fill (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (accept),
        .beat_i ((state_q == S_R) && i_RVALID),
        .data_i (i_RDATA),
        .line_o (fill_line),
        .done_o (fill_done)
    );

`ifdef L1D_PERF_CNT_EN
    logic [31:0] rd_hit_q, rd_miss_q, wr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_hit_q  <= '0;
            rd_miss_q <= '0;
            wr_q      <= '0;
        end else begin
            if (state_q == S_RDCHECK && i_m1_hit)  rd_hit_q  <= rd_hit_q + 1'b1;
            if (state_q == S_RDCHECK && !i_m1_hit) rd_miss_q <= rd_miss_q + 1'b1;
            if (state_q == S_WRCHECK)              wr_q      <= wr_q + 1'b1;
        end
    end

    assign o_rd_hit_cnt  = rd_hit_q;
    assign o_rd_miss_cnt = rd_miss_q;
    assign o_wr_cnt      = wr_q;
`else
    assign o_rd_hit_cnt  = 32'h0;
    assign o_rd_miss_cnt = 32'h0;
    assign o_wr_cnt      = 32'h0;
`endif
endmodule
